// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters.
// Each grant loads that requester's SPI mode, divider and word into the
// master, and a watchdog abandons transfers whose busy handshake stalls.
module spi_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data,
  input  logic [NUM_REQ-1:0]            cfg_cpol,
  input  logic [NUM_REQ-1:0]            cfg_cpha,
  input  logic [NUM_REQ*4-1:0]          cfg_clk_div,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            rsp_done,
  output logic [NUM_REQ-1:0]            rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic                          spi_enable,
  output logic                          spi_cpol,
  output logic                          spi_cpha,
  output logic [3:0]                    spi_clk_div,
  output logic [DATA_WIDTH-1:0]         spi_tx_data,
  input  logic                          spi_busy,
  input  logic                          spi_ss_n,
  input  logic [DATA_WIDTH-1:0]         spi_rx_data
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BSY,
    S_XFER
  } state_e;

  state_e        state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] sel_q;
  logic [WW-1:0] wdog_q;

  logic [IW-1:0] cand;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic [IW-1:0] sel_next;
  logic [WW-1:0] wdog_inc;
  logic          wdog_expired;

  assign sel_next     = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + IW'(1);
  assign wdog_inc     = wdog_q + WW'(1);
  assign wdog_expired = (wdog_inc == WW'(TIMEOUT_CYC - 1));

  // First asserted request at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IW'((32'(rr_q) + k) % NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Route the master's single slave select to the selected requester.
  always_comb begin
    cs_n = '1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cs_n[i] = ~((sel_q == IW'(i)) && !spi_ss_n);
    end
  end

  // Grant / transfer FSM with watchdog; all master-side and response outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      wdog_q      <= '0;
      spi_enable  <= 1'b0;
      spi_cpol    <= 1'b0;
      spi_cpha    <= 1'b0;
      spi_clk_div <= '0;
      spi_tx_data <= '0;
      req_ack     <= '0;
      rsp_done    <= '0;
      rsp_err     <= '0;
      rsp_data    <= '0;
    end else begin
      req_ack  <= '0;
      rsp_done <= '0;
      rsp_err  <= '0;
      if (state_q == S_IDLE) begin
        if (pick_vld && !spi_busy) begin
          sel_q             <= pick_idx;
          spi_enable        <= 1'b1;
          spi_tx_data       <= req_tx_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          spi_cpol          <= cfg_cpol[pick_idx];
          spi_cpha          <= cfg_cpha[pick_idx];
          spi_clk_div       <= cfg_clk_div[pick_idx*4 +: 4];
          req_ack[pick_idx] <= 1'b1;
          wdog_q            <= '0;
          state_q           <= S_START;
        end
      end else begin
        wdog_q <= wdog_inc;
        // Abort takes priority over any handshake progress in the same cycle.
        if (wdog_expired) begin
          spi_enable     <= 1'b0;
          rsp_err[sel_q] <= 1'b1;
          rr_q           <= sel_next;
          state_q        <= S_IDLE;
        end else begin
          case (state_q)
            S_START: begin
              spi_enable <= 1'b0;
              state_q    <= S_WAIT_BSY;
            end
            S_WAIT_BSY: begin
              if (spi_busy) state_q <= S_XFER;
            end
            S_XFER: begin
              if (!spi_busy) begin
                rsp_data        <= spi_rx_data;
                rsp_done[sel_q] <= 1'b1;
                rr_q            <= sel_next;
                state_q         <= S_IDLE;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a behavioural loopback SPI master
// and grant/response scoreboards filled when stimulus is applied.
module tb_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [63:0] req_tx_data;
  logic [3:0]  cfg_cpol;
  logic [3:0]  cfg_cpha;
  logic [15:0] cfg_clk_div;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_done;
  logic [3:0]  rsp_err;
  logic [15:0] rsp_data;
  logic [3:0]  cs_n;
  logic        spi_enable;
  logic        spi_cpol;
  logic        spi_cpha;
  logic [3:0]  spi_clk_div;
  logic [15:0] spi_tx_data;
  logic        spi_busy;
  logic        spi_ss_n;
  logic [15:0] spi_rx_data;

  spi_req_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (16),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_tx_data(req_tx_data),
    .cfg_cpol   (cfg_cpol),
    .cfg_cpha   (cfg_cpha),
    .cfg_clk_div(cfg_clk_div),
    .req_ack    (req_ack),
    .rsp_done   (rsp_done),
    .rsp_err    (rsp_err),
    .rsp_data   (rsp_data),
    .cs_n       (cs_n),
    .spi_enable (spi_enable),
    .spi_cpol   (spi_cpol),
    .spi_cpha   (spi_cpha),
    .spi_clk_div(spi_clk_div),
    .spi_tx_data(spi_tx_data),
    .spi_busy   (spi_busy),
    .spi_ss_n   (spi_ss_n),
    .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  // Behavioural master: busy/ss_n one cycle after enable, fixed length, rx = tx.
  logic        m_clr = 1'b0;
  logic        m_stall = 1'b0;
  logic        m_hold_busy = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ss_n = 1'b1;
  logic [15:0] m_rx = '0;
  logic [15:0] m_sh = '0;
  int          m_phase = 0;
  int          m_cnt = 0;

  assign spi_busy    = m_busy | m_hold_busy;
  assign spi_ss_n    = m_ss_n;
  assign spi_rx_data = m_rx;

  always @(posedge clk) begin
    if (m_clr) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_ss_n  <= 1'b1;
    end else begin
      case (m_phase)
        0: if (spi_enable && !m_stall) begin
             m_sh    <= spi_tx_data;
             m_phase <= 1;
           end
        1: begin
             m_busy  <= 1'b1;
             m_ss_n  <= 1'b0;
             m_cnt   <= 4;
             m_phase <= 2;
           end
        default: begin
             if (m_cnt == 0) begin
               m_busy  <= 1'b0;
               m_ss_n  <= 1'b1;
               m_rx    <= m_sh;
               m_phase <= 0;
             end else begin
               m_cnt <= m_cnt - 1;
             end
           end
      endcase
    end
  end

  typedef struct packed {
    logic [3:0]  ack;
    logic        cpol;
    logic        cpha;
    logic [3:0]  div;
    logic [15:0] tx;
  } ack_t;

  typedef struct packed {
    logic [3:0]  done;
    logic [3:0]  err;
    logic [15:0] data;
  } rsp_t;

  ack_t        ack_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] b_word[4];
  logic        b_cpol[4];
  logic        b_cpha[4];
  logic [3:0]  b_div[4];
  logic [15:0] exp_last;
  logic [1:0]  exp_sel;
  bit          drop_on_ack;
  bit          en_chk;
  int          en_age;
  int          acks_seen;
  int          n_rsp_seen;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [15:0] w, input logic cp,
                         input logic ch, input logic [3:0] d);
    b_word[i] = w;
    b_cpol[i] = cp;
    b_cpha[i] = ch;
    b_div[i]  = d;
    req_tx_data[i*16 +: 16] = w;
    cfg_cpol[i] = cp;
    cfg_cpha[i] = ch;
    cfg_clk_div[i*4 +: 4] = d;
  endtask

  task automatic expect_grant(input int unsigned i, input bit abort);
    ack_t a;
    rsp_t r;
    a.ack  = 4'(1 << i);
    a.cpol = b_cpol[i];
    a.cpha = b_cpha[i];
    a.div  = b_div[i];
    a.tx   = b_word[i];
    ack_q.push_back(a);
    r.done = abort ? 4'h0 : a.ack;
    r.err  = abort ? a.ack : 4'h0;
    r.data = abort ? exp_last : b_word[i];
    if (!abort) exp_last = b_word[i];
    rsp_q.push_back(r);
  endtask

  task automatic clear_sb();
    ack_q.delete();
    rsp_q.delete();
    exp_last   = '0;
    exp_sel    = '0;
    en_chk     = 1'b0;
    en_age     = 0;
    acks_seen  = 0;
    n_rsp_seen = 0;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    m_clr       = 1'b1;
    m_stall     = 1'b0;
    m_hold_busy = 1'b0;
    req_valid   = '0;
    clear_sb();
    repeat (2) @(negedge clk);
    m_clr   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic sample_cycle();
    ack_t       a;
    rsp_t       r;
    logic [3:0] cs_exp;
    cs_exp = 4'hF;
    if (!spi_ss_n) cs_exp[exp_sel] = 1'b0;
    chk("cs_n", cs_n, cs_exp);
    if (req_ack != 4'h0) begin
      chk("ack_after_done", acks_seen - n_rsp_seen, 0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", req_ack, 0);
      end else begin
        a = ack_q.pop_front();
        chk("req_ack", req_ack, a.ack);
        chk("enable_at_ack", spi_enable, 1);
        chk("spi_cpol", spi_cpol, a.cpol);
        chk("spi_cpha", spi_cpha, a.cpha);
        chk("spi_clk_div", spi_clk_div, a.div);
        chk("spi_tx_data", spi_tx_data, a.tx);
        for (int unsigned k = 0; k < 4; k++) if (a.ack[k]) exp_sel = 2'(k);
      end
      acks_seen++;
      en_age = 0;
      en_chk = 1'b1;
      if (drop_on_ack) req_valid = req_valid & ~req_ack;
    end else begin
      en_age++;
      if (en_chk) begin
        chk("enable_one_cycle", spi_enable, 0);
        en_chk = 1'b0;
      end
    end
    if ((rsp_done | rsp_err) != 4'h0) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", {rsp_done, rsp_err}, 0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_done", rsp_done, r.done);
        chk("rsp_err", rsp_err, r.err);
        chk("rsp_data", rsp_data, r.data);
        if (r.err != 4'h0) chk("wdog_latency", en_age, 15);
      end
      n_rsp_seen++;
      if (rsp_err != 4'h0) m_stall = 1'b0;
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_cycle();
    end
  endtask

  task automatic step_until(input int n_new, input int budget);
    int start;
    int cyc;
    start = n_rsp_seen;
    cyc   = 0;
    while ((n_rsp_seen - start) < n_new && cyc < budget) begin
      @(negedge clk);
      sample_cycle();
      cyc++;
    end
    if ((n_rsp_seen - start) < n_new) chk("rsp_timeout", n_rsp_seen - start, n_new);
  endtask

  task automatic idle_window(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("quiet_ack", req_ack, 0);
      chk("quiet_rsp", rsp_done | rsp_err, 0);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_enable", spi_enable, 0);
    chk("rst_cpol", spi_cpol, 0);
    chk("rst_cpha", spi_cpha, 0);
    chk("rst_clk_div", spi_clk_div, 0);
    chk("rst_tx_data", spi_tx_data, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_rsp_done", rsp_done, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
  endtask

  initial begin
    bit seen;
    reset_n     = 1'b1;
    req_valid   = '0;
    req_tx_data = '0;
    cfg_cpol    = '0;
    cfg_cpha    = '0;
    cfg_clk_div = '0;
    drop_on_ack = 1'b1;
    clear_sb();
    set_req(0, 16'hA5C3, 1'b0, 1'b0, 4'd2);
    set_req(1, 16'h1234, 1'b1, 1'b1, 4'd5);
    set_req(2, 16'h0F0F, 1'b0, 1'b0, 4'd0);
    set_req(3, 16'hBEEF, 1'b1, 1'b0, 4'd7);
    m_clr = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    chk("rst_cs_n", cs_n, 4'hF);
    m_clr   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Single requester, mode 0, loopback.
    drop_on_ack = 1'b1;
    expect_grant(0, 1'b0);
    req_valid = 4'b0001;
    step_until(1, 40);
    idle_window(4);

    // Round robin with every request held high.
    do_reset();
    drop_on_ack = 1'b0;
    expect_grant(0, 1'b0);
    expect_grant(1, 1'b0);
    expect_grant(2, 1'b0);
    expect_grant(3, 1'b0);
    expect_grant(0, 1'b0);
    req_valid = 4'hF;
    step_until(5, 200);
    req_valid = '0;
    idle_window(4);

    // Per-requester configuration reaches the master.
    do_reset();
    drop_on_ack = 1'b1;
    expect_grant(1, 1'b0);
    expect_grant(2, 1'b0);
    req_valid = 4'b0110;
    step_until(2, 80);

    // Watchdog: master never raises busy for requester 0.
    do_reset();
    drop_on_ack = 1'b1;
    m_stall = 1'b1;
    expect_grant(0, 1'b1);
    expect_grant(1, 1'b0);
    req_valid = 4'b0011;
    step_until(2, 100);

    // Late drop: requester 3 withdraws during requester 0's transfer.
    do_reset();
    drop_on_ack = 1'b1;
    expect_grant(0, 1'b0);
    req_valid = 4'b1001;
    step_n(3);
    req_valid[3] = 1'b0;
    step_until(1, 40);
    idle_window(12);
    expect_grant(1, 1'b0);
    expect_grant(0, 1'b0);
    req_valid = 4'b0011;
    step_until(2, 80);

    // Reset during requester 2's transfer, after requester 1 moved the pointer.
    do_reset();
    drop_on_ack = 1'b1;
    set_req(2, 16'h0F0F, 1'b1, 1'b1, 4'd3);
    expect_grant(1, 1'b0);
    expect_grant(2, 1'b0);
    req_valid = 4'b0110;
    step_until(1, 40);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      sample_cycle();
      if (spi_busy && acks_seen == 2) seen = 1'b1;
    end
    chk("reached_xfer", seen, 1);
    step_n(1);
    reset_n     = 1'b0;
    m_clr       = 1'b1;
    m_hold_busy = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    chk("mid_rst_cs_n", cs_n, 4'hF);
    chk("mid_rst_no_pulse", req_ack | rsp_done | rsp_err, 0);
    clear_sb();
    reset_n   = 1'b1;
    m_clr     = 1'b0;
    req_valid = 4'b0101;
    idle_window(10);
    m_hold_busy = 1'b0;
    expect_grant(0, 1'b0);
    expect_grant(2, 1'b0);
    step_until(2, 80);
    chk("sb_drained", ack_q.size() + rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
